// File: rtl/uart_rx_oversampler.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampler
//
// UART receive front-end. The asynchronous RX line is synchronized, a start
// edge is detected, and every bit is recovered with 16x oversampling and a
// 2-of-3 majority vote on oversample ticks 7, 8 and 9. A completed word is
// held in a single output register and handed off over a valid/ready
// interface together with its parity and framing status.
//
// Parameters
//   BAUD_DIV   clk cycles per oversample tick (>= 1); bit time = 16*BAUD_DIV
//   DATA_BITS  data bits per frame, 5..9, LSB first
//   PARITY     0 none, 1 even, 2 odd
//
// Ports
//   clk          in   sole clock
//   rst          in   synchronous active-high reset
//   RX           in   asynchronous serial line, idle high
//   rx_data      out  received word, LSB-aligned, upper bits zero
//   rx_valid     out  output register holds a word
//   rx_ready     in   consumer accepts the word when rx_valid && rx_ready
//   parity_err   out  parity mismatch for the held word
//   frame_err    out  stop bit sampled low for the held word
//   overrun_err  out  one-cycle pulse: a completed word was dropped
//   rx_break     out  one-cycle pulse on a break frame (UART_RX_BREAK_DETECT_EN)
//   rx_busy      out  receiver FSM is not idle
//
// Build option
//   UART_RX_BREAK_DETECT_EN  when defined, an all-zero frame with a low stop
//   bit is reported on rx_break instead of being delivered, and the receiver
//   waits for the line to return high before looking for the next start.
// -----------------------------------------------------------------------------
module uart_rx_oversampler #(
  parameter int unsigned BAUD_DIV  = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic       rx_break,
`endif
  output logic       rx_busy
);

  localparam int unsigned PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_RX_BREAK_DETECT_EN
    , S_BREAK
`endif
  } state_e;

  // Line synchronizer and edge detect
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic fall;

  // Oversampling timebase
  logic [PW-1:0] presc_q;
  logic [3:0]    samp_q;
  logic          tick;

  // Frame assembly
  state_e     state_q;
  logic [1:0] vote_q;
  logic       maj;
  logic [3:0] bit_cnt_q;
  logic [8:0] shift_q, shift_d;
  logic       par_acc_q, par_err_q;
  logic       is_break;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       ones_q;
  logic       break_q;
`endif

  // Output register
  logic [8:0] rx_data_q;
  logic       rx_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;

  // NOTE: the synchronizer resets to the idle (high) level so that leaving
  // reset with a quiet line can never look like a falling start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;
  assign tick = (presc_q == PW'(BAUD_DIV - 1));

  // Two samples are already captured; the third is the live line at tick 9.
  assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);

  // Bits enter at the top and move down, so after DATA_BITS shifts the first
  // (LSB) bit sits at index 9-DATA_BITS.
  assign shift_d = {maj, shift_q[8:1]};

`ifdef UART_RX_BREAK_DETECT_EN
  assign is_break = ~ones_q & ~maj;
`else
  assign is_break = 1'b0;
`endif

  // NOTE: every register here is written with <=, so an assignment later in
  // the block wins for the same cycle; this is how a new load overrides the
  // handshake clear that precedes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      samp_q       <= '0;
      vote_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      ones_q       <= 1'b0;
      break_q      <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q   <= 1'b0;
`endif

      if (rx_valid_q && rx_ready) begin
        rx_valid_q   <= 1'b0;
        parity_err_q <= 1'b0;
        frame_err_q  <= 1'b0;
      end

      if (state_q != S_IDLE) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          samp_q <= samp_q + 4'd1;
          if (samp_q == 4'd7) vote_q[0] <= rx_sync_q;
          if (samp_q == 4'd8) vote_q[1] <= rx_sync_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q   <= S_START;
            presc_q   <= '0;
            samp_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            ones_q    <= 1'b0;
`endif
          end
        end

        S_START: begin
          if (tick && samp_q == 4'd9 && maj) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tick && samp_q == 4'd15) begin
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (tick && samp_q == 4'd9) begin
            shift_q   <= shift_d;
            par_acc_q <= par_acc_q ^ maj;
            bit_cnt_q <= bit_cnt_q + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
            ones_q    <= ones_q | maj;
`endif
          end else if (tick && samp_q == 4'd15 && bit_cnt_q == 4'(DATA_BITS)) begin
            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          if (tick && samp_q == 4'd9) begin
            // Even: the bit must equal the data XOR; odd: its inverse.
            par_err_q <= (maj ^ par_acc_q) ^ (PARITY == 2);
`ifdef UART_RX_BREAK_DETECT_EN
            ones_q    <= ones_q | maj;
`endif
          end else if (tick && samp_q == 4'd15) begin
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          // The frame completes at the stop-bit centre; the rest of the stop
          // bit is left to the edge detector.
          if (tick && samp_q == 4'd9) begin
            if (is_break) begin
`ifdef UART_RX_BREAK_DETECT_EN
              state_q <= S_BREAK;
              break_q <= 1'b1;
`endif
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (!rx_valid_q || rx_ready) begin
                rx_data_q    <= shift_q >> (9 - DATA_BITS);
                rx_valid_q   <= 1'b1;
                parity_err_q <= par_err_q;
                frame_err_q  <= ~maj;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
        end

`ifdef UART_RX_BREAK_DETECT_EN
        S_BREAK: begin
          if (rx_sync_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = busy_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign rx_break    = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampler
//
// Two receivers share clock and reset: u_n (8N1) and u_p (8E1). A table of
// frames with expected words drives the directed cases, hand-written
// sequences cover the glitch, reset, overrun and break/framing corners, and a
// randomized phase compares every delivered word with a frame-level model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_oversampler;

  localparam int BD       = 4;
  localparam int BIT_CLKS = 16 * BD;

  logic clk = 1'b0;
  logic rst;
  logic rx_n, rx_p, rdy_n, rdy_p;
  logic [8:0] data_n, data_p;
  logic valid_n, valid_p, perr_n, perr_p, ferr_n, ferr_p;
  logic ovr_n, ovr_p, busy_n, busy_p;
`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_n, brk_p;
`endif

  always #5 clk = ~clk;

  uart_rx_oversampler #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0)) u_n (
    .clk(clk), .rst(rst), .RX(rx_n),
    .rx_data(data_n), .rx_valid(valid_n), .rx_ready(rdy_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overrun_err(ovr_n),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk_n),
`endif
    .rx_busy(busy_n)
  );

  uart_rx_oversampler #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(1)) u_p (
    .clk(clk), .rst(rst), .RX(rx_p),
    .rx_data(data_p), .rx_valid(valid_p), .rx_ready(rdy_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun_err(ovr_p),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk_p),
`endif
    .rx_busy(busy_p)
  );

  typedef struct packed {
    logic       valid;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       busy;
    logic       brk;
  } obs_t;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  typedef enum int {PRE_NONE, PRE_GLITCH, PRE_RESET} pre_e;

  typedef struct {
    int         sel;
    pre_e       pre;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  word_t exp_n[$], exp_p[$], got_n[$], got_p[$];
  logic  mon_en = 1'b0;
  int    mon_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    o = '0;
    if (sel == 0) begin
      o.valid = valid_n; o.data = data_n; o.perr = perr_n; o.ferr = ferr_n;
      o.ovr = ovr_n; o.busy = busy_n;
`ifdef UART_RX_BREAK_DETECT_EN
      o.brk = brk_n;
`endif
    end else begin
      o.valid = valid_p; o.data = data_p; o.perr = perr_p; o.ferr = ferr_p;
      o.ovr = ovr_p; o.busy = busy_p;
`ifdef UART_RX_BREAK_DETECT_EN
      o.brk = brk_p;
`endif
    end
    return o;
  endfunction

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_n = v; else rx_p = v;
  endtask

  task automatic set_rdy(input int sel, input logic v);
    if (sel == 0) rdy_n = v; else rdy_p = v;
  endtask

  // Expected cycle (counted from the negedge that drives the start bit) on
  // which rx_valid is first seen: 3 cycles to detect the edge, tick g of the
  // frame lands BD*(g+1) cycles later, the stop decision is tick 9 of the
  // last bit, and the output register adds one more cycle.
  function automatic int valid_latency(input int sel);
    int nb;
    nb = (sel == 1) ? 11 : 10;
    return 3 + BD * (16 * (nb - 1) + 10);
  endfunction

  // Drives one frame bit-by-bit on the selected line. rdy_at >= 0 raises that
  // DUT's rx_ready for exactly the cycle numbered rdy_at. cut > 0 stops the
  // frame early at that cycle, leaving the line as it is.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic pbit,
                            input logic stop, input int rdy_at, input int cut,
                            output int valid_at, output int ovr_cnt, output int brk_cnt);
    logic [15:0] bits;
    int nb, cyc;
    obs_t o;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    nb = 9;
    if (sel == 1) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stop;
    nb++;
    valid_at = -1; ovr_cnt = 0; brk_cnt = 0; cyc = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < BIT_CLKS; k++) begin
        @(negedge clk);
        o = obs(sel);
        if (valid_at < 0 && o.valid) valid_at = cyc;
        if (o.ovr) ovr_cnt++;
        if (o.brk) brk_cnt++;
        if (cut > 0 && cyc == cut) return;
        set_line(sel, bits[b]);
        if (rdy_at >= 0 && cyc == rdy_at) set_rdy(sel, 1'b1);
        else if (rdy_at >= 0 && cyc == rdy_at + 1) set_rdy(sel, 1'b0);
        cyc++;
      end
    end
    @(negedge clk);
    o = obs(sel);
    if (valid_at < 0 && o.valid) valid_at = cyc;
    if (o.ovr) ovr_cnt++;
    if (o.brk) brk_cnt++;
    set_line(sel, 1'b1);
  endtask

  task automatic consume(input int sel);
    set_rdy(sel, 1'b1);
    @(negedge clk);
    set_rdy(sel, 1'b0);
  endtask

  // 20-clock low pulse on an idle line: a false start that must not deliver.
  task automatic do_glitch();
    int busy_seen, valid_seen;
    obs_t o;
    busy_seen = 0; valid_seen = 0;
    @(negedge clk);
    rx_n = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 19) rx_n = 1'b1;
      o = obs(0);
      if (o.busy) busy_seen++;
      if (o.valid) valid_seen++;
    end
    check("glitch busy pulsed", 32'(busy_seen != 0), 32'd1);
    check("glitch no valid", 32'(valid_seen), 32'd0);
    o = obs(0);
    check("glitch back idle", 32'(o.busy), 32'd0);
  endtask

  // Leaves a word with frame_err held, then resets during data bit 4 of the
  // next frame (a 1 bit, so the line is high when reset releases).
  task automatic do_reset();
    int va, oc, bc;
    obs_t o;
    send_frame(0, 8'h81, 1'b0, 1'b0, -1, 0, va, oc, bc);
    o = obs(0);
    check("pre-reset word held", {o.valid, o.data, o.ferr}, {1'b1, 9'h081, 1'b1});
    repeat (10) @(negedge clk);
    send_frame(0, 8'hFF, 1'b0, 1'b1, -1, 5 * BIT_CLKS + BIT_CLKS / 2, va, oc, bc);
    o = obs(0);
    check("busy before reset", 32'(o.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = obs(0);
    check("outputs after mid-frame reset", 32'(o), 32'd0);
    repeat (3 * BIT_CLKS) @(negedge clk);
    o = obs(0);
    check("idle after reset", 32'(o), 32'd0);
  endtask

  // Frame-level reference: what the consumer should see for a frame.
  function automatic void model(input int sel, input logic [7:0] d, input logic pb,
                                input logic st);
    word_t w;
    logic  odd_ones;
`ifdef UART_RX_BREAK_DETECT_EN
    if (d == 8'h00 && (sel == 0 || pb == 1'b0) && st == 1'b0) return;
`endif
    odd_ones = ($countones(d) % 2) == 1;
    w.data = {1'b0, d};
    w.perr = (sel == 1) ? (pb != odd_ones) : 1'b0;
    w.ferr = ~st;
    if (sel == 0) exp_n.push_back(w); else exp_p.push_back(w);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_n && rdy_n) got_n.push_back(word_t'({data_n, perr_n, ferr_n}));
      if (valid_p && rdy_p) got_p.push_back(word_t'({data_p, perr_p, ferr_p}));
      if (ovr_n || ovr_p) mon_ovr++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[9];
    vec_t  v;
    obs_t  o;
    int    va, oc, bc, nmin;
    int    sel;
    logic [7:0] d;
    logic  pb, st;

    vecs[0] = '{0, PRE_NONE,   8'hA5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, PRE_NONE,   8'h03, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
    vecs[2] = '{1, PRE_NONE,   8'h03, 1'b0, 1'b1, 9'h003, 1'b0, 1'b0};
    vecs[3] = '{0, PRE_NONE,   8'h55, 1'b0, 1'b0, 9'h055, 1'b0, 1'b1};
    vecs[4] = '{0, PRE_GLITCH, 8'h3C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0};
    vecs[5] = '{0, PRE_RESET,  8'hF0, 1'b0, 1'b1, 9'h0F0, 1'b0, 1'b0};
    vecs[6] = '{1, PRE_NONE,   8'h80, 1'b1, 1'b1, 9'h080, 1'b0, 1'b0};
    vecs[7] = '{1, PRE_NONE,   8'hFF, 1'b1, 1'b1, 9'h0FF, 1'b1, 1'b0};
    vecs[8] = '{0, PRE_NONE,   8'hFF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};

    rst = 1'b1; rx_n = 1'b1; rx_p = 1'b1; rdy_n = 1'b0; rdy_p = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state u_n", 32'(obs(0)), 32'd0);
    check("reset state u_p", 32'(obs(1)), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle after reset release", 32'(obs(0)) | 32'(obs(1)), 32'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      case (v.pre)
        PRE_GLITCH: do_glitch();
        PRE_RESET:  do_reset();
        default:    ;
      endcase
      send_frame(v.sel, v.data, v.pbit, v.stop, -1, 0, va, oc, bc);
      o = obs(v.sel);
      check($sformatf("v%0d valid latency", i), 32'(va), 32'(valid_latency(v.sel)));
      check($sformatf("v%0d word", i), {o.valid, o.data, o.perr, o.ferr},
            {1'b1, v.exp_data, v.exp_perr, v.exp_ferr});
      check($sformatf("v%0d no overrun", i), 32'(oc), 32'd0);
      repeat (8) @(negedge clk);
      o = obs(v.sel);
      check($sformatf("v%0d held stable", i), {o.valid, o.data, o.perr, o.ferr},
            {1'b1, v.exp_data, v.exp_perr, v.exp_ferr});
      consume(v.sel);
      o = obs(v.sel);
      check($sformatf("v%0d handshake clears", i), {o.valid, o.perr, o.ferr, o.busy}, 32'd0);
      repeat (10) @(negedge clk);
    end

    // Overrun: 0x11 held, 0x22 dropped, 0x33 loaded on the handshake cycle
    send_frame(0, 8'h11, 1'b0, 1'b1, -1, 0, va, oc, bc);
    o = obs(0);
    check("ovr first word", {o.valid, o.data}, {1'b1, 9'h011});
    repeat (10) @(negedge clk);
    send_frame(0, 8'h22, 1'b0, 1'b1, -1, 0, va, oc, bc);
    o = obs(0);
    check("ovr old word kept", {o.valid, o.data}, {1'b1, 9'h011});
    check("ovr single pulse", 32'(oc), 32'd1);
    repeat (10) @(negedge clk);
    send_frame(0, 8'h33, 1'b0, 1'b1, valid_latency(0) - 1, 0, va, oc, bc);
    o = obs(0);
    check("ovr same-cycle load", {o.valid, o.data, o.ferr}, {1'b1, 9'h033, 1'b0});
    check("ovr none on same-cycle read", 32'(oc), 32'd0);
    consume(0);
    repeat (10) @(negedge clk);

    // All-zero frame with a low stop bit
    send_frame(0, 8'h00, 1'b0, 1'b0, -1, 0, va, oc, bc);
`ifdef UART_RX_BREAK_DETECT_EN
    check("break pulse count", 32'(bc), 32'd1);
    check("break not delivered", 32'(va < 0), 32'd1);
    repeat (10) @(negedge clk);
    o = obs(0);
    check("break returns idle", {o.valid, o.busy}, 32'd0);
`else
    o = obs(0);
    check("zero frame delivered", {o.valid, o.data, o.perr, o.ferr}, {1'b1, 9'h000, 1'b0, 1'b1});
    consume(0);
    repeat (10) @(negedge clk);
`endif

    // Randomized frames against the frame-level model
    rdy_n = 1'b1; rdy_p = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 1));
      d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      model(sel, d, pb, st);
      send_frame(sel, d, pb, st, -1, 0, va, oc, bc);
      repeat ($urandom_range(2, 30)) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    mon_en = 1'b0;

    check("rand u_n word count", 32'(got_n.size()), 32'(exp_n.size()));
    check("rand u_p word count", 32'(got_p.size()), 32'(exp_p.size()));
    nmin = (got_n.size() < exp_n.size()) ? got_n.size() : exp_n.size();
    for (int i = 0; i < nmin; i++) check($sformatf("rand u_n word %0d", i), 32'(got_n[i]), 32'(exp_n[i]));
    nmin = (got_p.size() < exp_p.size()) ? got_p.size() : exp_p.size();
    for (int i = 0; i < nmin; i++) check($sformatf("rand u_p word %0d", i), 32'(got_p[i]), 32'(exp_p[i]));
    check("rand no overrun with ready high", 32'(mon_ovr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

Receive front-end for the UART datapath. It recovers serial frames from the asynchronous `RX` line using 16x oversampling, majority voting and start-bit validation, and hands each completed word downstream over a valid/ready interface. Its 9-bit output word matches the `data_in`/`data_out` width used by the UART driver, so it can replace that driver's receive half or feed the host-side logic. Parity, framing and overrun errors are reported alongside each word.

## Interface
- `BAUD_DIV`, 4: clk cycles per oversample tick (≥1); bit time = 16·BAUD_DIV clocks.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `RX`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  9  received word, LSB-aligned; bits above DATA_BITS are 0.
- `rx_valid`  out  1  word held in output register.
- `rx_ready`  in  1  consumer accepts word when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch for the held word.
- `frame_err`  out  1  stop bit sampled low for the held word.
- `overrun_err`  out  1  one-cycle pulse; a completed word was dropped.
- `rx_busy`  out  1  FSM not in IDLE.

## Operation
- `RX` passes through a 2-FF synchronizer; both flops reset to 1. Falling-edge detect on the synchronized line.
- Prescaler counts 0..BAUD_DIV-1 and emits `tick` at BAUD_DIV-1. Both the prescaler and the 4-bit sample counter reset to 0 on the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge moves to START.
  - START: samples at ticks 7, 8, 9. If the majority is 1 (false start), return to IDLE; otherwise go to DATA at tick 15.
  - DATA: each bit is the majority of samples 7/8/9, shifted in LSB first. After DATA_BITS bits go to PARITY (PARITY≠0) or STOP.
  - PARITY: majority bit compared with the XOR of the data bits (even) or its inverse (odd).
  - STOP: majority taken at tick 9. Frame completes at that tick and the FSM returns to IDLE immediately, without waiting for the end of the stop bit.
- On completion:
  - If the output register is empty, or is being read in the same cycle (`rx_valid && rx_ready`), load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`.
  - Otherwise keep the old word, drop the new one, and pulse `overrun_err`.
- A handshake without a new load clears `rx_valid`, `parity_err` and `frame_err`.
- A line held low after a frame produces no falling edge, so no new start is detected until the line returns high.
- Reset mid-frame: FSM goes to IDLE, partial word is discarded, output register is cleared.
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `rx_busy`=0.

## Timing
- Synchronizer latency: 2 cycles. Falling edge detected 3 cycles after the `RX` transition.
- `rx_valid` is registered and asserts the cycle after the stop-bit tick-9 decision.
- `rx_valid` holds, and `rx_data` and the error flags stay stable, until the handshake.
- `rx_busy` goes high the cycle after the start edge and low the cycle after the STOP decision (or false start).
- `overrun_err` is high for exactly 1 cycle.

## Configuration
- `UART_RX_BREAK_DETECT_EN` defined:
  - Break condition: all data bits 0, parity bit (if any) 0, and stop bit 0.
  - The word is not delivered. Output `rx_break` (1 bit, reset 0) pulses for 1 cycle.
  - FSM enters a BREAK state and waits for the synchronized line to return to 1 before IDLE.
- Undefined: no `rx_break` port and no BREAK state. The same frame is delivered as `rx_data`=0 with `frame_err`=1.

## Test plan
- BAUD_DIV=4, 8N1: send 0xA5 -> `rx_data`=0x0A5, `rx_valid` until `rx_ready`, all errors 0.
- PARITY=1: send 0x03 with parity bit 1 -> `rx_data`=0x003, `parity_err`=1. Same data with parity bit 0 -> `parity_err`=0.
- Low glitch of 20 clocks on idle line -> `rx_busy` pulses, no `rx_valid`, FSM back in IDLE. A following 0x3C is received correctly.
- Send 0x55 with stop bit 0 -> `rx_data`=0x055, `frame_err`=1.
- `rx_ready`=0, send 0x11 then 0x22 -> `rx_data` stays 0x011 and `overrun_err` pulses once. Assert `rx_ready` on the completion cycle of a third byte 0x33 -> 0x033 loaded, no overrun.
- Assert `rst` at data bit 4 of a frame -> all outputs at reset values next cycle. The next frame 0xF0 is received cleanly. With macro: 0x00 plus low stop bit -> `rx_break` pulse, no `rx_valid`.
